// File: rtl/icache_fill_responder.sv
// L1 I-cache miss responder: fills a 256-bit line from 32-bit memory in 8 beats.
// Define ICFILL_LINEBUF_EN to serve repeat requests for the last filled line without memory traffic.
module icache_fill_responder (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  L2_addr_read,
  input  logic         L2_read_en,
  output logic [255:0] L2_block_read,
  output logic         L2_stall,
  output logic         mem_rd_en,
  output logic [31:0]  mem_addr,
  input  logic [31:0]  mem_rd_data,
  input  logic         mem_rd_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [2:0]  beat;
  logic [26:0] line;
  logic [26:0] req_line;
  logic        hit;
  logic        last_cap;
  logic        unused_addr_bits;

  assign req_line = L2_addr_read[31:5];
  assign unused_addr_bits = ^L2_addr_read[4:0];
  assign last_cap = (state == FILL) && mem_rd_valid && (beat == 3'd7);

`ifdef ICFILL_LINEBUF_EN
  logic        buf_vld;
  logic [26:0] buf_tag;

  assign hit = buf_vld && (buf_tag == req_line);

  // Remember the tag of the last fully assembled line.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld <= 1'b0;
      buf_tag <= '0;
    end else if (last_cap) begin
      buf_vld <= 1'b1;
      buf_tag <= line;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Control FSM: latch the line, step beats, one-cycle DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      line  <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (L2_read_en) begin
            line  <= req_line;
            beat  <= '0;
            state <= hit ? DONE : FILL;
          end
        end
        (state == FILL): begin
          if (mem_rd_valid) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7)
              state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line assembly: each returned word lands in its beat slot.
  always_ff @(posedge clk) begin
    if (rst)
      L2_block_read <= '0;
    else if ((state == FILL) && mem_rd_valid)
      L2_block_read[{beat, 5'b0} +: 32] <= mem_rd_data;
  end

  assign mem_rd_en = (state == FILL);
  assign mem_addr  = {line, beat, 2'b00};
  assign L2_stall  = L2_read_en &
                     ~((state == DONE) && (req_line == line));

endmodule

// File: tb/tb_icache_fill_responder.sv
// Scoreboard bench for icache_fill_responder.
// Memory model answers reads; monitor checks every served line.
module tb_icache_fill_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  L2_addr_read;
  logic         L2_read_en;
  logic [255:0] L2_block_read;
  logic         L2_stall;
  logic         mem_rd_en;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rd_data;
  logic         mem_rd_valid;

  int checks = 0;
  int errors = 0;

  logic [255:0] exp_q[$];
  logic [31:0]  addr_log[$];
  int gap = 0;
  int gcnt = 0;
  int rd_cnt = 0;
  int addr_moves = 0;
  bit force_valid = 1'b0;
  logic prev_en = 1'b0;
  logic prev_valid = 1'b0;
  logic [31:0] prev_addr = '0;
  int lat;

  icache_fill_responder dut (
    .clk          (clk),
    .rst          (rst),
    .L2_addr_read (L2_addr_read),
    .L2_read_en   (L2_read_en),
    .L2_block_read(L2_block_read),
    .L2_stall     (L2_stall),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [31:0] base);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++)
      r[32*k +: 32] = base + 32'(k);
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: words of lines with addr bit 13 set are 0xB0+k, else 0xA0+k.
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (force_valid) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hDEAD_BEEF;
      end else if (mem_rd_en) begin
        rd_cnt++;
        if (prev_en && !prev_valid && mem_addr !== prev_addr)
          addr_moves++;
        if (gcnt == gap) begin
          mem_rd_valid = 1'b1;
          gcnt = 0;
          mem_rd_data = (mem_addr[13] ? 32'hB0 : 32'hA0) +
                        {29'd0, mem_addr[4:2]};
          addr_log.push_back(mem_addr);
        end else begin
          mem_rd_valid = 1'b0;
          gcnt++;
        end
      end else begin
        mem_rd_valid = 1'b0;
        gcnt = 0;
      end
      prev_en    = mem_rd_en;
      prev_valid = mem_rd_valid;
      prev_addr  = mem_addr;
    end
  end

  // Monitor: every served line must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (L2_read_en && !L2_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_serve got %h want none", L2_block_read);
        end else begin
          chk("served_line", L2_block_read, exp_q.pop_front());
        end
      end
    end
  end

  task automatic request(input logic [31:0] a, input logic [31:0] sw_addr,
                         input int sw_beat, output int l);
    @(posedge clk);
    #1;
    addr_log.delete();
    rd_cnt = 0;
    addr_moves = 0;
    L2_addr_read = a;
    L2_read_en = 1'b1;
    l = 0;
    forever begin
      @(negedge clk);
      if (!L2_stall) break;
      l++;
      if (l > 300) begin
        checks++;
        errors++;
        $display("FAIL request_timeout got %0d want <300", l);
        break;
      end
      @(posedge clk);
      #1;
      if (sw_beat >= 0 && addr_log.size() == sw_beat && L2_addr_read == a)
        L2_addr_read = sw_addr;
    end
    @(posedge clk);
    #1;
    L2_read_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    L2_read_en = 1'b0;
    L2_addr_read = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_block", L2_block_read, '0);
    chk("reset_rd_en", {255'd0, mem_rd_en}, 256'd0);
    chk("reset_addr", {224'd0, mem_addr}, 256'd0);
    chk("reset_stall", {255'd0, L2_stall}, {255'd0, L2_read_en});

    // Back-to-back memory, line 0x1040.
    gap = 0;
    exp_q.push_back(line_of(32'hA0));
    request(32'h0000_1040, 32'h0, -1, lat);
    chk("lat_every_cycle", 256'(lat), 256'd9);
    chk("beats_every_cycle", 256'(addr_log.size()), 256'd8);
    for (int k = 0; k < 8; k++)
      chk("beat_addr", {224'd0, addr_log[k]}, 256'(32'h1040 + 4 * k));
    @(negedge clk);
    chk("idle_rd_en", {255'd0, mem_rd_en}, 256'd0);
    chk("block_hold", L2_block_read, line_of(32'hA0));

    // Memory valid every third cycle, line 0x2000.
    gap = 2;
    exp_q.push_back(line_of(32'hB0));
    request(32'h0000_2000, 32'h0, -1, lat);
    chk("lat_gap3", 256'(lat), 256'd25);
    chk("beats_gap3", 256'(addr_log.size()), 256'd8);
    chk("addr_stable", 256'(addr_moves), 256'd0);
    chk("gap3_first", {224'd0, addr_log[0]}, 256'h2000);
    chk("gap3_last", {224'd0, addr_log[7]}, 256'h201C);
    gap = 0;

    // Address switches to 0x2000 at beat 3 of a 0x1040 fill.
    exp_q.push_back(line_of(32'hB0));
    request(32'h0000_1040, 32'h0000_2000, 3, lat);
    chk("lat_switch", 256'(lat), 256'd19);
    chk("beats_switch", 256'(addr_log.size()), 256'd16);
    chk("switch_old_end", {224'd0, addr_log[7]}, 256'h105C);
    chk("switch_new_start", {224'd0, addr_log[8]}, 256'h2000);
    chk("switch_new_end", {224'd0, addr_log[15]}, 256'h201C);

    // Reset at beat 5 with memory valids arriving late.
    @(posedge clk);
    #1;
    addr_log.delete();
    L2_addr_read = 32'h0000_4000;
    L2_read_en = 1'b1;
    for (int n = 0; n < 50 && addr_log.size() < 5; n++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_beat5", 256'(addr_log.size()), 256'd5);
    rst = 1'b1;
    L2_read_en = 1'b0;
    force_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd_en", {255'd0, mem_rd_en}, 256'd0);
    chk("rst_mid_addr", {224'd0, mem_addr}, 256'd0);
    chk("rst_mid_block", L2_block_read, '0);
    chk("rst_mid_stall", {255'd0, L2_stall}, 256'd0);
    @(posedge clk);
    #1;
    force_valid = 1'b0;
    @(negedge clk);
    chk("late_valid_block", L2_block_read, '0);
    chk("late_valid_rd_en", {255'd0, mem_rd_en}, 256'd0);
    chk("late_valid_addr", {224'd0, mem_addr}, 256'd0);

    // Same line twice after reset.
    exp_q.push_back(line_of(32'hB0));
    request(32'h0000_2000, 32'h0, -1, lat);
    chk("first_lat", 256'(lat), 256'd9);
    chk("first_reads", 256'(rd_cnt), 256'd8);
    exp_q.push_back(line_of(32'hB0));
    request(32'h0000_2010, 32'h0, -1, lat);
`ifdef ICFILL_LINEBUF_EN
    chk("repeat_lat", 256'(lat), 256'd1);
    chk("repeat_reads", 256'(rd_cnt), 256'd0);
`else
    chk("repeat_lat", 256'(lat), 256'd9);
    chk("repeat_reads", 256'(rd_cnt), 256'd8);
`endif

    @(negedge clk);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
